// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: multiplexed 8-digit 7-segment scan controller.
//
// Each digit stays selected for CLK_DIV enabled clock cycles. The first
// BLANK_CYCLES cycles of every digit slot drive seg = 0 to suppress ghosting.
// Display data is double-buffered: host writes land in a shadow buffer and
// are copied to the active buffer only at a frame boundary (or immediately
// when scanning is disabled), so a frame is never torn.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         scan enable; when low, prescaler and pointer hold, seg = 0
//   load       single-cycle write strobe into the shadow buffer
//   load_data  8 hex nibbles, nibble i -> digit i
//   load_dp    per-digit decimal point enable
//   load_blank per-digit blank (set bit forces seg = 0 for that digit)
//   cs_pointer selected digit index, 0..7
//   seg        {dp,g,f,e,d,c,b,a}, active high, registered
//   frame_done one-cycle pulse after the 7->0 pointer wrap
//   pending    shadow buffer holds data not yet committed
module led_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_blank,
  output logic [2:0]  cs_pointer,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned    CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  TERM      = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    ptr_nx;
  logic          tick, wrap, commit;

  logic [31:0]   sh_data, act_data, act_data_nx;
  logic [7:0]    sh_dp, sh_blank;
  logic [7:0]    act_dp, act_blank, act_dp_nx, act_blank_nx;
  logic [3:0]    nib;
  logic [7:0]    seg_nx;

  always_comb begin
    tick   = en && (cnt == TERM);
    wrap   = tick && (cs_pointer == 3'd7);
    // With scanning stopped there is no frame to tear, so commit at once.
    commit = pending && (wrap || !en);

    cnt_nx = cnt;
    ptr_nx = cs_pointer;
    if (en) begin
      if (tick) begin
        cnt_nx = '0;
        ptr_nx = cs_pointer + 3'd1;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end

    act_data_nx  = commit ? sh_data  : act_data;
    act_dp_nx    = commit ? sh_dp    : act_dp;
    act_blank_nx = commit ? sh_blank : act_blank;

    // seg is built from post-edge state so it always matches cs_pointer.
    nib    = act_data_nx[{ptr_nx, 2'b00} +: 4];
    seg_nx = '0;
    if (en && (cnt_nx >= BLANK_END) && !act_blank_nx[ptr_nx])
      seg_nx = {act_dp_nx[ptr_nx], hex7(nib)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cs_pointer <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      cnt        <= cnt_nx;
      cs_pointer <= ptr_nx;
      seg        <= seg_nx;
      frame_done <= wrap;
      act_data   <= act_data_nx;
      act_dp     <= act_dp_nx;
      act_blank  <= act_blank_nx;
      // A load coinciding with a commit lands after the commit has taken the
      // old shadow, leaving pending set for the next frame boundary.
      if (load) begin
        sh_data  <= load_data;
        sh_dp    <= load_dp;
        sh_blank <= load_blank;
        pending  <= 1'b1;
      end else if (commit) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1).
// The reference model tracks the number of enabled cycles since reset and
// derives pointer/prescaler/frame position from it arithmetically.
module tb_led_scan_ctrl;

  localparam int CD = 4;
  localparam int BC = 1;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0;
  logic [7:0]  load_blank = '0;
  logic [2:0]  cs_pointer;
  logic [7:0]  seg;
  logic        frame_done;
  logic        pending;

  led_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
    .load_dp(load_dp), .load_blank(load_blank), .cs_pointer(cs_pointer),
    .seg(seg), .frame_done(frame_done), .pending(pending));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  string phase = "init";

  // reference model state
  int          ecount;
  logic [31:0] m_sh_d, m_act_d;
  logic [7:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  logic        m_pend, m_en, m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic int m_ptr();
    return (ecount / CD) % 8;
  endfunction

  function automatic logic [7:0] m_seg();
    int d;
    logic [3:0] n;
    d = m_ptr();
    n = 4'((m_act_d >> (4 * d)) & 32'hF);
    if (!m_en || (ecount % CD) < BC || m_act_bl[d]) return 8'h00;
    return {m_act_dp[d], HEX[n]};
  endfunction

  task automatic m_reset();
    ecount = 0;
    m_sh_d = '0; m_act_d = '0; m_sh_dp = '0; m_act_dp = '0;
    m_sh_bl = '0; m_act_bl = '0;
    m_pend = 1'b0; m_en = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic check_all();
    chk("ptr",   32'(cs_pointer), 32'(m_ptr()));
    chk("seg",   32'(seg),        32'(m_seg()));
    chk("frame", 32'(frame_done), 32'(m_wrap));
    chk("pend",  32'(pending),    32'(m_pend));
  endtask

  // one clock: model the edge using the inputs present at it, then check
  task automatic step();
    logic w;
    @(posedge clk);
    w = en && (ecount % CD == CD - 1) && (m_ptr() == 7);
    if (m_pend && (!en || w)) begin
      m_act_d = m_sh_d; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl;
      m_pend = 1'b0;
    end
    if (load) begin
      m_sh_d = load_data; m_sh_dp = load_dp; m_sh_bl = load_blank;
      m_pend = 1'b1;
    end
    if (en) ecount++;
    m_en = en;
    m_wrap = w;
    #1;
    check_all();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // advance (with en=1) until the frame position ecount%32 equals pos
  task automatic goto_pos(input int pos);
    int n;
    n = (pos - (ecount % (8 * CD)) + 8 * CD) % (8 * CD);
    run(n);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    load_data = d; load_dp = dp; load_blank = bl; load = 1'b1;
    step();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    m_reset();
    check_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    m_reset();
    phase = "reset";
    #23;
    check_all();
    rst = 1'b0;

    phase = "scan";
    en = 1'b1;
    run(70);

    phase = "load_dis";
    async_reset();
    en = 1'b0;
    do_load(32'h7654_3210, 8'h00, 8'h00);
    step();
    en = 1'b1;
    run(36);

    phase = "load_mid";
    goto_pos(3 * CD);
    do_load(32'hFFFF_FFFF, 8'h00, 8'h00);
    run(50);

    phase = "dp_blank";
    do_load(32'h89AB_CDEF, 8'h01, 8'h80);
    run(70);

    phase = "load_wrap";
    goto_pos(2 * CD + 1);
    do_load(32'h1111_1111, 8'h00, 8'h00);
    goto_pos(8 * CD - 1);
    do_load(32'h2222_2222, 8'hFF, 8'h00);
    run(70);

    phase = "en_hold";
    goto_pos(5 * CD + 2);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(6);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        load_data = $urandom; load_dp = 8'($urandom); load_blank = 8'($urandom);
        load = 1'b1;
      end
      step();
    end

    phase = "rst_mid";
    en = 1'b1;
    do_load(32'hDEAD_BEEF, 8'h00, 8'h00);
    async_reset();
    run(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Multiplexed 8-digit 7-segment scan controller.
- Cycles a digit pointer at a programmable rate and drives the 3-bit `cs_pointer` consumed by the downstream chip-select decoder.
- In the same cycle, presents the segment pattern for the selected digit.
- Display data is double-buffered: host writes never tear a frame. A short blanking window after each digit change suppresses ghosting.

Parameters:
- CLK_DIV, 50000, clk cycles each digit stays selected; legal range 2..2^20.
- BLANK_CYCLES, 16, cycles at the start of each digit slot with `seg` forced to 0; must be < CLK_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable.
- load  input  1  single-cycle write strobe for the shadow buffer.
- load_data  input  32  8 hex nibbles; nibble i is `load_data[4i+3:4i]` and maps to digit i.
- load_dp  input  8  decimal-point enable per digit.
- load_blank  input  8  per-digit blank; a set bit makes that digit show `seg` = 0.
- cs_pointer  output  3  currently selected digit index, 0..7.
- seg  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active high.
- frame_done  output  1  one-cycle pulse when the pointer wraps 7->0.
- pending  output  1  shadow buffer holds data not yet committed.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - Prescaler = 0, `cs_pointer` = 0.
  - Active and shadow buffers all 0; `pending` = 0.
  - `seg` = 0x00, `frame_done` = 0.
  - Reset mid-frame discards any pending load.
- Prescaler:
  - While `en` = 1, counts 0..CLK_DIV-1.
  - The terminal count (CLK_DIV-1) is a "tick". On the tick edge the prescaler returns to 0 and `cs_pointer` increments modulo 8.
  - A 7->0 wrap also asserts `frame_done` for exactly the cycle after the edge.
- en = 0:
  - Prescaler and `cs_pointer` hold their values; `seg` = 0; `frame_done` = 0.
  - On rising `en`, scanning resumes from the held count.
- Segment output:
  - `seg` is registered and updates on the same edge as `cs_pointer`, so `seg` always describes the digit currently on `cs_pointer`.
  - `seg` = 0 while prescaler < BLANK_CYCLES.
  - `seg` = 0 when the active blank bit for that digit is set.
  - Otherwise `seg` = {dp_i, hex7(nibble_i)}.
- hex7 table:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
- Load / commit:
  - `load` = 1 captures `load_data`, `load_dp` and `load_blank` into the shadow buffer and sets `pending` on the next edge.
  - Back-to-back loads: the last one wins.
  - Commit copies shadow to active and clears `pending`. It occurs on the wrap edge (tick with `cs_pointer` = 7) when `pending` = 1.
  - If `en` = 0, commit instead occurs on the first edge where `pending` = 1.
- Simultaneous load and commit edge:
  - The commit takes the shadow contents from before the edge.
  - The new data enters the shadow buffer and `pending` stays 1, so it commits at the next frame boundary.
  - If `pending` was 0 before the edge, the new data likewise waits one frame.
- Committed data is first visible on digit 0 of the new frame, with the blanking window still applied.
- All outputs are glitch-free registered signals.

Test Plan:
All scenarios use CLK_DIV=4, BLANK_CYCLES=1 unless stated.
1. Reset, then `en`=1 → `cs_pointer` steps 0,1,...,7,0 every 4 cycles; `frame_done` pulses once per 32 cycles, in the cycle after the 7->0 edge; no pulse at any other pointer change.
2. Load `load_data`=0x76543210 with `en`=0 → `pending` = 1 for one cycle, then commits. With `en`=1, digit 0 shows `seg` 0x00 for 1 cycle, then 0x3F for 3 cycles; digit 3 shows 0x4F.
3. Load 0xFFFFFFFF mid-frame at `cs_pointer`=3 → `pending`=1; digits 3..7 still show old data; after the wrap every digit shows 0x71 and `pending`=0.
4. Set `load_dp`=0x01 and `load_blank`=0x80 → digit 0 shows `seg` = {1, hex7(d0)}, i.e. bit 7 set; digit 7 shows 0x00 for the whole slot.
5. Assert `load` on the exact wrap edge → commit uses the prior shadow; new data appears only after the following wrap; `pending` stays 1 across that frame.
6. Drop `en` at prescaler=2, `cs_pointer`=5 → `seg`=0 and the pointer holds. Re-enable → the pointer advances after 2 more cycles. Assert `rst` mid-frame → all outputs 0 asynchronously and `pending` cleared.
